// File: rtl/bist_pkg.sv
// Shared definitions for the built-in self-test checkers: sequencer states,
// default MISR polynomial and the single-step MISR compaction function.
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } bist_state_e;

    localparam logic [31:0] DEFAULT_MISR_POLY = 32'h04C1_1DB7;

    function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                              input logic [31:0] data,
                                              input logic [31:0] poly);
        return {sig[30:0], 1'b0} ^ (sig[31] ? poly : 32'h0) ^ data;
    endfunction

endpackage

// File: rtl/misr32.sv
// 32-bit multiple-input signature register with load-seed and compaction enable.
module misr32
    import bist_pkg::*;
#(
    parameter logic [31:0] POLY = DEFAULT_MISR_POLY,
    parameter logic [31:0] SEED = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        en_i,
    input  logic [31:0] data_i,
    output logic [31:0] sig_o,
    output logic [31:0] sig_next_o
);

    logic [31:0] sig_q;

    // Look-ahead value lets the owner judge the final word in the same cycle it lands.
    assign sig_next_o = misr_step(sig_q, data_i, POLY);
    assign sig_o      = sig_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= SEED;
        end else if (load_i) begin
            sig_q <= SEED;
        end else if (en_i) begin
            sig_q <= sig_next_o;
        end
    end

endmodule

// File: rtl/imem_readback_verifier.sv
// Reads back a window of instruction memory after load, compacts it into a MISR
// signature, tallies ECC events and reports pass/fail against a golden signature.
module imem_readback_verifier
    import bist_pkg::*;
#(
    parameter int          N_WORDS   = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] MISR_POLY = DEFAULT_MISR_POLY,
    parameter logic [31:0] MISR_SEED = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic [31:0] expected_sig,
    output logic        imem_re,
    output logic [31:0] imem_raddr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_s_err,
    input  logic        imem_d_err,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] signature,
    output logic [7:0]  s_err_cnt,
    output logic        d_err_seen,
    output logic [31:0] d_err_addr
);

    localparam int CW = $clog2(N_WORDS + 1);

    bist_state_e   state_q;
    logic [31:0]   addr_q;
    logic [CW-1:0] issued_q;
    logic          cap_q;
    logic [31:0]   cap_addr_q;
    logic [31:0]   exp_q;
    logic [7:0]    s_cnt_q;
    logic          d_seen_q;
    logic [31:0]   d_addr_q;
    logic          done_q;
    logic          pass_q;
    logic [31:0]   sig_next;
    logic          issue;
    logic          last_issue;
    logic          misr_load;

    assign issue      = (state_q == ST_READ) && !pause;
    assign last_issue = issue && (issued_q == CW'(N_WORDS - 1));
    assign misr_load  = (state_q == ST_IDLE) && start;

    misr32 #(
        .POLY (MISR_POLY),
        .SEED (MISR_SEED)
    ) u_misr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (misr_load),
        .en_i       (cap_q),
        .data_i     (imem_rdata),
        .sig_o      (signature),
        .sig_next_o (sig_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= BASE_ADDR;
            issued_q   <= '0;
            cap_q      <= 1'b0;
            cap_addr_q <= '0;
            exp_q      <= '0;
            s_cnt_q    <= '0;
            d_seen_q   <= 1'b0;
            d_addr_q   <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            cap_q  <= issue;
            done_q <= 1'b0;
            if (issue) begin
                cap_addr_q <= addr_q;
                addr_q     <= addr_q + 32'd4;
                issued_q   <= issued_q + CW'(1);
            end
            // cap_q marks the cycle in which the previous request's data is on the bus.
            if (cap_q) begin
                if (imem_s_err && (s_cnt_q != 8'hFF)) s_cnt_q <= s_cnt_q + 8'd1;
                if (imem_d_err) begin
                    d_seen_q <= 1'b1;
                    if (!d_seen_q) d_addr_q <= cap_addr_q;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q  <= ST_READ;
                        addr_q   <= BASE_ADDR;
                        issued_q <= '0;
                        exp_q    <= expected_sig;
                        s_cnt_q  <= '0;
                        d_seen_q <= 1'b0;
                        d_addr_q <= '0;
                        pass_q   <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (last_issue) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Final word is still being folded in, so judge on the look-ahead signature.
                    state_q <= ST_REPORT;
                    done_q  <= 1'b1;
                    pass_q  <= (sig_next == exp_q) && !(d_seen_q || imem_d_err);
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign imem_re    = issue;
    assign imem_raddr = addr_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign pass       = pass_q;
    assign s_err_cnt  = s_cnt_q;
    assign d_err_seen = d_seen_q;
    assign d_err_addr = d_addr_q;

endmodule

// File: tb/tb_imem_readback_verifier.sv
// Bench for imem_readback_verifier: three instances (1, 2 and 16 words) against a
// behavioural memory responder and a loop-based signature/ECC reference model.
module tb_imem_readback_verifier;

    localparam logic [31:0] POLY = 32'h04C1_1DB7;
    localparam int          NW   [3] = '{1, 2, 16};
    localparam logic [31:0] BASE [3] = '{32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000};

    logic        clk;
    logic        rst     [3];
    logic        start   [3];
    logic        pause   [3];
    logic [31:0] esig    [3];
    logic        re      [3];
    logic [31:0] raddr   [3];
    logic [31:0] rdata   [3];
    logic        s_err   [3];
    logic        d_err   [3];
    logic        busy    [3];
    logic        done    [3];
    logic        pass    [3];
    logic [31:0] sig     [3];
    logic [7:0]  scnt    [3];
    logic        dseen   [3];
    logic [31:0] daddr   [3];

    logic [31:0] mem_w [3][16];
    bit          mem_s [3][16];
    bit          mem_d [3][16];
    logic [31:0] alog  [3][1024];
    int          re_cnt[3] = '{0, 0, 0};

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        imem_readback_verifier #(
            .N_WORDS   (NW[g]),
            .BASE_ADDR (BASE[g])
        ) u_dut (
            .clk          (clk),
            .rst          (rst[g]),
            .start        (start[g]),
            .pause        (pause[g]),
            .expected_sig (esig[g]),
            .imem_re      (re[g]),
            .imem_raddr   (raddr[g]),
            .imem_rdata   (rdata[g]),
            .imem_s_err   (s_err[g]),
            .imem_d_err   (d_err[g]),
            .busy         (busy[g]),
            .done         (done[g]),
            .pass         (pass[g]),
            .signature    (sig[g]),
            .s_err_cnt    (scnt[g]),
            .d_err_seen   (dseen[g]),
            .d_err_addr   (daddr[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int widx(input int g, input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE[g]) >> 2;
        return int'(off[3:0]);
    endfunction

    // One-cycle-latency memory; junk data on idle cycles exposes spurious captures.
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (re[g]) begin
                rdata[g] <= mem_w[g][widx(g, raddr[g])];
                s_err[g] <= mem_s[g][widx(g, raddr[g])];
                d_err[g] <= mem_d[g][widx(g, raddr[g])];
                alog[g][re_cnt[g] % 1024] <= raddr[g];
                re_cnt[g] <= re_cnt[g] + 1;
            end else begin
                rdata[g] <= $urandom;
                s_err[g] <= 1'b0;
                d_err[g] <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fill(input int g, input bit rnd_err);
        for (int i = 0; i < 16; i++) begin
            mem_w[g][i] = $urandom;
            mem_s[g][i] = rnd_err && ($urandom_range(0, 3) == 0);
            mem_d[g][i] = rnd_err && ($urandom_range(0, 7) == 0);
        end
    endtask

    // Signature and ECC bookkeeping straight from the readback rules.
    task automatic model(input int g, output logic [31:0] s, output int sc, output int fd);
        s = 32'h0; sc = 0; fd = -1;
        for (int i = 0; i < NW[g]; i++) begin
            s = (s << 1) ^ (s[31] ? POLY : 32'h0) ^ mem_w[g][i];
            if (mem_s[g][i] && sc < 255) sc++;
            if (mem_d[g][i] && fd < 0) fd = i;
        end
    endtask

    task automatic run(input int g, input logic [31:0] exp, input int pa, input int pl,
                       input int sp_at, output int dcyc, output int cnt0);
        int cyc;
        @(negedge clk);
        start[g] = 1'b1; esig[g] = exp;
        cnt0 = re_cnt[g];
        @(negedge clk);
        start[g] = 1'b0;
        chk("busy_after_start", 32'(busy[g]), 32'h1);
        cyc = 1; dcyc = -1;
        while (cyc < 200) begin
            pause[g] = (pl > 0) && (cyc >= pa) && (cyc < pa + pl);
            if (cyc == sp_at) begin start[g] = 1'b1; esig[g] = ~exp; end
            else begin start[g] = 1'b0; esig[g] = exp; end
            if (done[g]) begin dcyc = cyc; break; end
            @(negedge clk);
            cyc++;
        end
        pause[g] = 1'b0; start[g] = 1'b0; esig[g] = exp;
        chk("done_cycle", 32'(dcyc), 32'(NW[g] + 2 + pl));
    endtask

    task automatic check_result(input int g, input logic [31:0] exp, input int cnt0);
        logic [31:0] ms; int sc, fd, bad; logic p;
        model(g, ms, sc, fd);
        chk("signature", sig[g], ms);
        chk("pass", 32'(pass[g]), 32'((ms == exp) && (fd < 0)));
        chk("s_err_cnt", 32'(scnt[g]), 32'(sc));
        chk("d_err_seen", 32'(dseen[g]), 32'(fd >= 0));
        chk("d_err_addr", daddr[g], (fd >= 0) ? BASE[g] + 32'(4 * fd) : 32'h0);
        bad = 0;
        for (int i = 0; i < NW[g]; i++)
            if (alog[g][(cnt0 + i) % 1024] !== BASE[g] + 32'(4 * i)) bad++;
        chk("addr_contig", 32'(bad), 32'h0);
        chk("read_count", 32'(re_cnt[g] - cnt0), 32'(NW[g]));
        p = pass[g];
        @(negedge clk);
        chk("done_pulse", 32'(done[g]), 32'h0);
        chk("busy_end", 32'(busy[g]), 32'h0);
        chk("pass_held", 32'(pass[g]), 32'(p));
    endtask

    typedef struct {
        int          g;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] exp_in;
        logic [31:0] sig;
        bit          pass;
    } vec_t;

    initial begin
        vec_t tbl[5];
        int dcyc, cnt0, d2, c2, sc, fd, w;
        logic [31:0] ms, s_ref;

        for (int g = 0; g < 3; g++) begin
            rst[g] = 1'b1; start[g] = 1'b0; pause[g] = 1'b0; esig[g] = 32'h0;
            for (int i = 0; i < 16; i++) begin
                mem_w[g][i] = 32'h0; mem_s[g][i] = 1'b0; mem_d[g][i] = 1'b0;
            end
        end
        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("rst_re", 32'(re[g]), 32'h0);
            chk("rst_busy", 32'(busy[g]), 32'h0);
            chk("rst_done", 32'(done[g]), 32'h0);
            chk("rst_pass", 32'(pass[g]), 32'h0);
            chk("rst_dseen", 32'(dseen[g]), 32'h0);
            chk("rst_sig", sig[g], 32'h0);
            chk("rst_raddr", raddr[g], BASE[g]);
            chk("rst_scnt", 32'(scnt[g]), 32'h0);
            chk("rst_daddr", daddr[g], 32'h0);
            rst[g] = 1'b0;
        end

        // Directed vectors for the 1- and 2-word instances (instance 1 wraps past 2^32).
        tbl[0] = '{g: 0, w0: 32'h0000_0001, w1: 32'h0, exp_in: 32'h0000_0001, sig: 32'h0000_0001, pass: 1'b1};
        tbl[1] = '{g: 1, w0: 32'h8000_0000, w1: 32'h0, exp_in: 32'h04C1_1DB7, sig: 32'h04C1_1DB7, pass: 1'b1};
        tbl[2] = '{g: 1, w0: 32'h8000_0001, w1: 32'h0, exp_in: 32'h04C1_1DB7, sig: 32'h04C1_1DB5, pass: 1'b0};
        tbl[3] = '{g: 0, w0: 32'hDEAD_BEEF, w1: 32'h0, exp_in: 32'h0000_0000, sig: 32'hDEAD_BEEF, pass: 1'b0};
        tbl[4] = '{g: 1, w0: 32'h0000_0000, w1: 32'h0000_0001, exp_in: 32'h0000_0001, sig: 32'h0000_0001, pass: 1'b1};
        for (int t = 0; t < 5; t++) begin
            mem_w[tbl[t].g][0] = tbl[t].w0;
            mem_w[tbl[t].g][1] = tbl[t].w1;
            run(tbl[t].g, tbl[t].exp_in, 0, 0, 0, dcyc, cnt0);
            chk("vec_sig", sig[tbl[t].g], tbl[t].sig);
            chk("vec_pass", 32'(pass[tbl[t].g]), 32'(tbl[t].pass));
            check_result(tbl[t].g, tbl[t].exp_in, cnt0);
        end

        // Pause mid-read: same signature, done exactly three cycles later.
        fill(2, 1'b0);
        model(2, ms, sc, fd);
        run(2, ms, 0, 0, 0, dcyc, cnt0);
        s_ref = sig[2];
        check_result(2, ms, cnt0);
        run(2, ms, 6, 3, 0, d2, c2);
        chk("pause_sig_same", sig[2], s_ref);
        chk("pause_delay", 32'(d2 - dcyc), 32'd3);
        check_result(2, ms, c2);

        // ECC events: corrected on words 2 and 5, uncorrectable on 7 and 9.
        fill(2, 1'b0);
        mem_s[2][2] = 1'b1; mem_s[2][5] = 1'b1;
        mem_d[2][7] = 1'b1; mem_d[2][9] = 1'b1;
        model(2, ms, sc, fd);
        run(2, ms, 0, 0, 0, dcyc, cnt0);
        chk("ecc_scnt", 32'(scnt[2]), 32'd2);
        chk("ecc_daddr", daddr[2], 32'h0000_001C);
        chk("ecc_pass", 32'(pass[2]), 32'h0);
        check_result(2, ms, cnt0);

        // Reset in the middle of a run, then a clean rerun.
        fill(2, 1'b0);
        for (int i = 0; i < 4; i++) mem_s[2][i] = 1'b1;
        mem_d[2][2] = 1'b1;
        @(negedge clk);
        start[2] = 1'b1; esig[2] = 32'h0; cnt0 = re_cnt[2];
        @(negedge clk);
        start[2] = 1'b0;
        w = 0;
        while ((re_cnt[2] - cnt0) < 4 && w < 50) begin @(negedge clk); w++; end
        chk("rst_wait_reads", 32'(re_cnt[2] - cnt0), 32'd4);
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        chk("midrst_busy", 32'(busy[2]), 32'h0);
        chk("midrst_re", 32'(re[2]), 32'h0);
        chk("midrst_scnt", 32'(scnt[2]), 32'h0);
        chk("midrst_dseen", 32'(dseen[2]), 32'h0);
        chk("midrst_sig", sig[2], 32'h0);
        chk("midrst_raddr", raddr[2], 32'h0);
        for (int i = 0; i < 16; i++) begin mem_s[2][i] = 1'b0; mem_d[2][i] = 1'b0; end
        model(2, ms, sc, fd);
        run(2, ms, 0, 0, 0, dcyc, cnt0);
        check_result(2, ms, cnt0);

        // Start pulsed while busy with a different golden value: ignored.
        fill(2, 1'b0);
        model(2, ms, sc, fd);
        run(2, ms, 0, 0, 5, dcyc, cnt0);
        check_result(2, ms, cnt0);
        w = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done[2] || busy[2]) w++;
        end
        chk("no_second_done", 32'(w), 32'h0);

        // Random words, ECC flags, pause windows and golden values.
        for (int it = 0; it < 12; it++) begin
            int pl, pa;
            logic [31:0] e;
            fill(2, 1'b1);
            model(2, ms, sc, fd);
            e  = ($urandom_range(0, 1) == 1) ? ms : ms ^ (32'h1 << $urandom_range(0, 31));
            pl = $urandom_range(0, 4);
            pa = $urandom_range(1, 16);
            run(2, e, pa, pl, 0, dcyc, cnt0);
            check_result(2, e, cnt0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
